// File: rtl/crypto_stream_v2.sv
// crypto_stream_v2: AXI-Stream packet XOR cipher with per-packet key latch,
// header byte skip, optional per-beat key rotation and byte counters.
module crypto_stream_v2 #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int NUM_KEYS             = 4,
  parameter int KEY_SEL_LSB          = 16,
  parameter int HDR_SKIP_BYTES       = 14,
  parameter int FIFO_DEPTH_BITS      = 2,
  parameter int NUM_RW_REGS          = NUM_KEYS + 1
) (
  input  logic                                      axi_aclk,
  input  logic                                      axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]          s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic                                      s_axis_tvalid,
  input  logic                                      s_axis_tlast,
  output logic                                      s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]          m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  input  logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_regs,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_defaults,
  output logic [31:0]                               pkt_count,
  output logic [31:0]                               bytes_enc
);
  localparam int W     = C_M_AXIS_DATA_WIDTH;
  localparam int NB    = W / 8;
  localparam int TU    = C_M_AXIS_TUSER_WIDTH;
  localparam int RW    = C_S_AXI_DATA_WIDTH;
  localparam int KW    = $clog2(NUM_KEYS);
  localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
  localparam int FW    = W + NB + TU + 1;
  localparam int NW    = $clog2(NB + 1);
  localparam logic [FIFO_DEPTH_BITS:0] C_NF = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);

  typedef enum logic {S_SOP, S_BODY} state_t;

  state_t                     r_state, w_state_nxt;
  logic [FW-1:0]              r_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wp, r_rp;
  logic [FIFO_DEPTH_BITS:0]   r_cnt;
  logic                       r_up;
  logic                       r_en, r_rot;
  logic [31:0]                r_key;
  logic [7:0]                 r_b;
  logic [W-1:0]               r_tdata;
  logic [NB-1:0]              r_tstrb;
  logic [TU-1:0]              r_tuser;
  logic                       r_tvalid, r_tlast;
  logic [NW-1:0]              r_nenc;
  logic [31:0]                r_pkt, r_bytes;

  logic                       w_wr, w_rd, w_sop, w_en, w_rot, w_last;
  logic [FW-1:0]              w_head;
  logic [W-1:0]               w_data, w_xdata;
  logic [NB-1:0]              w_strb;
  logic [TU-1:0]              w_user;
  logic [KW-1:0]              w_ksel;
  logic [31:0]                w_keys [NUM_KEYS];
  logic [31:0]                w_key, w_rk;
  logic [63:0]                w_rr;
  logic [7:0]                 w_b;
  logic [15:0]                w_base;
  logic [NW-1:0]              w_nenc;
  logic                       w_unused;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    assign w_keys[k] = rw_regs[RW*(k+1) +: 32];
  end
  for (genvar k = 0; k < NUM_RW_REGS; k++) begin : g_def
    assign rw_defaults[RW*k +: RW] = (k == 0) ? RW'(1) : RW'(32'h01234567 + k - 1);
  end
  assign w_unused = ^rw_regs[RW-1:2];

  // tready is held low until the first edge after reset release
  assign s_axis_tready = r_up && (r_cnt < C_NF);
  assign w_wr   = s_axis_tvalid && s_axis_tready;
  assign w_rd   = (r_cnt != '0) && (!r_tvalid || m_axis_tready);
  assign w_head = r_mem[r_rp];
  assign w_data = w_head[FW-1 -: W];
  assign w_strb = w_head[TU+1 +: NB];
  assign w_user = w_head[1 +: TU];
  assign w_last = w_head[0];

  always_ff @(posedge axi_aclk) begin
    if (w_wr) r_mem[r_wp] <= {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_up  <= 1'b0;
    end else begin
      r_up  <= 1'b1;
      r_wp  <= w_wr ? r_wp + 1'b1 : r_wp;
      r_rp  <= w_rd ? r_rp + 1'b1 : r_rp;
      r_cnt <= r_cnt + {{FIFO_DEPTH_BITS{1'b0}}, w_wr} - {{FIFO_DEPTH_BITS{1'b0}}, w_rd};
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= S_SOP;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_rd) w_state_nxt = w_last ? S_SOP : S_BODY;
  end

  // on SOP the live registers are used and captured; later beats reuse the capture
  assign w_sop  = r_state == S_SOP;
  assign w_ksel = w_user[KEY_SEL_LSB +: KW];
  assign w_en   = w_sop ? rw_regs[0] : r_en;
  assign w_rot  = w_sop ? rw_regs[1] : r_rot;
  assign w_key  = w_sop ? w_keys[w_ksel] : r_key;
  assign w_b    = w_sop ? 8'd0 : r_b;
  assign w_rr   = {w_key, w_key} << w_b[4:0];
  assign w_rk   = w_rot ? w_rr[63:32] : w_key;
  assign w_base = 16'(w_b) * 16'(NB);

  // lane l carries packet byte NB-1-l of the beat
  always_comb begin
    w_xdata = w_data;
    w_nenc  = '0;
    for (int l = 0; l < NB; l++) begin
      if (w_en && w_strb[l] && (w_base + 16'(NB - 1 - l)) >= 16'(HDR_SKIP_BYTES)) begin
        w_xdata[8*l +: 8] = w_data[8*l +: 8] ^ w_rk[8*(l%4) +: 8];
        w_nenc = w_nenc + 1'b1;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_en  <= 1'b0;
      r_rot <= 1'b0;
      r_key <= '0;
      r_b   <= '0;
    end else if (w_rd) begin
      r_en  <= w_en;
      r_rot <= w_rot;
      r_key <= w_key;
      r_b   <= w_last ? 8'd0 : (&w_b ? w_b : w_b + 8'd1);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tstrb  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_nenc   <= '0;
      r_pkt    <= '0;
      r_bytes  <= '0;
    end else begin
      if (w_rd) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_xdata;
        r_tstrb  <= w_strb;
        r_tuser  <= w_user;
        r_tlast  <= w_last;
        r_nenc   <= w_nenc;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
      if (r_tvalid && m_axis_tready) begin
        r_pkt   <= r_pkt + {31'd0, r_tlast};
        r_bytes <= r_bytes + 32'(r_nenc);
      end
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tstrb  = r_tstrb;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign pkt_count     = r_pkt;
  assign bytes_enc     = r_bytes;
endmodule

// File: doc/crypto_stream_v2.md
CRYPTO_STREAM_V2 -- requirements
Module: crypto_stream_v2

Interface
REQ-001 Parameters SHALL be:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width; multiple of 32.
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; equal to master.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width.
- C_S_AXI_DATA_WIDTH, 32, register word width.
- NUM_KEYS, 4, key table size; power of 2, at least 2.
- KEY_SEL_LSB, 16, tuser bit where the key index (log2(NUM_KEYS) bits) starts.
- HDR_SKIP_BYTES, 14, leading packet bytes passed unencrypted; range 0..255.
- FIFO_DEPTH_BITS, 2, input FIFO depth = 2**FIFO_DEPTH_BITS.
- NUM_RW_REGS, NUM_KEYS+1, number of rw words.

REQ-002 Ports SHALL be:
- axi_aclk  in  1  sole clock; all logic on the rising edge.
- axi_aresetn  in  1  reset; one clock; asynchronous assert, active-low.
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  W/W/8/TU/1/1  upstream AXI-Stream.
- s_axis_tready  out  1  upstream ready.
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  W/W/8/TU/1/1  downstream AXI-Stream.
- m_axis_tready  in  1  downstream ready.
- rw_regs  in  NUM_RW_REGS*32  word0 = control (bit0 enable, bit1 rotate); word k (1..NUM_KEYS) = key k-1.
- rw_defaults  out  NUM_RW_REGS*32  word0 = 0x00000001; key k = 0x01234567 + k.
- pkt_count  out  32  packets emitted.
- bytes_enc  out  32  bytes XORed.

Function
REQ-003 The input SHALL be a first-word-fall-through FIFO of 2**FIFO_DEPTH_BITS entries; s_axis_tready = !nearly_full; a write occurs on s_axis_tvalid & s_axis_tready.
REQ-004 The output SHALL be one registered stage, loaded when FIFO is non-empty and (!m_axis_tvalid | m_axis_tready); the FIFO read is that same condition; there SHALL be no bubble under continuous ready.
REQ-005 Latency: beat accepted at edge N SHALL appear on m_axis at edge N+1 when the output stage is empty.
REQ-006 m_axis_tdata/tstrb/tuser/tlast SHALL be held stable while m_axis_tvalid & !m_axis_tready.
REQ-007 The FSM SHALL have states SOP (next beat starts a packet) and BODY. A SOP beat with tlast = 0 goes to BODY; a BODY beat with tlast = 1 goes to SOP; a SOP beat with tlast = 1 stays in SOP.
REQ-008 On the SOP beat, enable, rotate and key[tuser[KEY_SEL_LSB +: log2(NUM_KEYS)]] SHALL be latched for the whole packet; register changes mid-packet SHALL have no effect until the next SOP.
REQ-009 Beat index b SHALL be 0 at SOP, increment per emitted beat, and saturate at 255.
REQ-010 Byte ordering: packet byte 0 of a beat SHALL be tdata[W-1 -: 8]; beat byte index = b*(W/8) + lane.
REQ-011 Keystream SHALL be the 32-bit key replicated W/32 times, key[31:24] in the MSB.
REQ-012 When rotate = 1, the key used for beat b SHALL be rotl(key, b mod 32).
REQ-013 Byte lane L SHALL be XORed iff enable = 1, packet byte index >= HDR_SKIP_BYTES, and tstrb[L] = 1; all other lanes pass unchanged.
REQ-014 tuser, tstrb and tlast SHALL pass unmodified.
REQ-015 pkt_count SHALL increment by 1 on every m-side handshake with tlast = 1.
REQ-016 bytes_enc SHALL increment by the number of XORed lanes on each m-side handshake.
REQ-017 Both counters SHALL wrap modulo 2**32.
REQ-018 A FIFO write and read in the same cycle SHALL both occur; a full FIFO SHALL never drop or overwrite data.

Reset
REQ-019 While axi_aresetn = 0, the following SHALL be forced immediately, independent of the clock: m_axis_tvalid = 0, m_axis_tdata/tstrb/tuser/tlast = 0, FIFO empty, FSM = SOP, b = 0, pkt_count = 0, bytes_enc = 0.
REQ-020 Reset mid-packet SHALL discard the partial packet; the first beat accepted after deassertion SHALL be treated as SOP.
REQ-021 s_axis_tready SHALL be 0 during reset and 1 on the first edge after deassertion.

Verification
REQ-022 Enable = 1, rotate = 0, key0 = 0xA5A5A5A5, a 3-beat packet of zeros with tuser index 0 -> beat0 bytes 0..13 = 0x00 and bytes 14..31 = 0xA5; beats 1 and 2 all 0xA5; pkt_count = 1; bytes_enc = 82.
REQ-023 Rotate = 1, key2 = 0x80000001, tuser index 2, 2-beat zero packet, HDR_SKIP_BYTES = 0 -> beat0 words = 0x80000001, beat1 words = 0x00000003.
REQ-024 Enable = 0, any packet -> output bit-identical to input; bytes_enc unchanged.
REQ-025 m_axis_tready held low for 10 cycles with continuous input -> s_axis_tready falls when nearly full; no beat lost or duplicated; output held stable.
REQ-026 Key1 rewritten during beat 1 of a 4-beat packet -> all 4 beats use the old key; the next packet uses the new key.
REQ-027 axi_aresetn pulsed low during beat 2 of a 5-beat packet -> m_axis_tvalid = 0 immediately; the next packet is encrypted from the SOP header skip.
